// File: rtl/adder_pkg.sv
// Shared types and constants for the serial 3-bit-per-cycle adder and its slice.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int SLICE_W = 3;

  // Number of compute cycles needed to cover a WIDTH-bit operand.
  function automatic int slices_of(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/add3_slice.sv
// Combinational 3-bit ripple-carry adder; drop-in point for partitioned or approximate slices.
module add3_slice
  import adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/serial_adder_3b.sv
// Wide adder computing A + B + cin three bits per clock with a carry register between cycles.
module serial_adder_3b
  import adder_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int SLICES = slices_of(WIDTH);
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("serial_adder_3b: WIDTH must be a positive multiple of 3");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;

  add3_slice u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // NOTE: the operand shift registers carry no reset; they are always loaded
  // on acceptance before being read, so resetting them only costs routing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      sum_q     <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            b_q      <= in_b;
            carry    <= in_cin;
            cnt      <= '0;
            state    <= RUN;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          // New slice result enters at the top; after SLICES shifts slice 0 sits at bit 0.
          sum_q <= WIDTH'({slice_s, sum_q} >> SLICE_W);
          a_q   <= a_q >> SLICE_W;
          b_q   <= b_q >> SLICE_W;
          carry <= slice_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            out_cout  <= slice_cout;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign out_sum = sum_q;

endmodule

// File: tb/tb_serial_adder_3b.sv
// Self-checking bench for serial_adder_3b at WIDTH=24 and WIDTH=3 against an arithmetic model.
module tb_serial_adder_3b;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // WIDTH=24 instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_a = '0;
  logic [23:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_sum;
  logic        out_cout;
  logic        busy;

  // WIDTH=3 instance
  logic       n_in_valid = 1'b0;
  logic       n_in_ready;
  logic [2:0] n_in_a = '0;
  logic [2:0] n_in_b = '0;
  logic       n_in_cin = 1'b0;
  logic       n_out_valid;
  logic       n_out_ready = 1'b0;
  logic [2:0] n_out_sum;
  logic       n_out_cout;
  logic       n_busy;

  int checks = 0;
  int errors = 0;

  serial_adder_3b #(.WIDTH(24)) u_dut24 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  serial_adder_3b #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_a(n_in_a), .in_b(n_in_b), .in_cin(n_in_cin),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_sum(n_out_sum), .out_cout(n_out_cout), .busy(n_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one 24-bit transaction, report the held result, its latency and any timeout.
  task automatic run24(input logic [23:0] a, input logic [23:0] b, input logic cin,
                       input int stall, output logic [23:0] sum, output logic cout,
                       output int lat, output bit to);
    int n;
    to = 1'b0;
    n  = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) to = 1'b1;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = 24'($urandom); in_b = 24'($urandom); in_cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    if (!out_valid) to = 1'b1;
    sum  = out_sum;
    cout = out_cout;
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic cin,
                      input int stall, output logic [2:0] sum, output logic cout,
                      output int lat, output bit to);
    int n;
    to = 1'b0;
    n  = 0;
    while (!n_in_ready && n < 50) begin tick(); n++; end
    if (!n_in_ready) to = 1'b1;
    n_in_a = a; n_in_b = b; n_in_cin = cin; n_in_valid = 1'b1;
    tick();
    n_in_valid = 1'b0;
    lat = 0;
    while (!n_out_valid && lat < 50) begin tick(); lat++; end
    if (!n_out_valid) to = 1'b1;
    sum  = n_out_sum;
    cout = n_out_cout;
    repeat (stall) tick();
    n_out_ready = 1'b1;
    tick();
    n_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({out_valid, busy, in_ready, out_cout} !== 4'b0000 || out_sum !== 24'h0) begin
      errors++;
      $display("FAIL reset_state valid/busy/ready/cout=%b sum=%h, required 0000 sum=000000",
               {out_valid, busy, in_ready, out_cout}, out_sum);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || n_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready=%b/%b, required 1/1", in_ready, n_in_ready);
    end
  endtask

  task automatic test_directed();
    logic [23:0] va [4] = '{24'h000001, 24'hFFFFFF, 24'hFFFFFF, 24'h123456};
    logic [23:0] vb [4] = '{24'h000001, 24'h000000, 24'hFFFFFF, 24'h654321};
    logic        vc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [24:0] exp_v [4] = '{25'h0000002, 25'h1000000, 25'h1FFFFFF, 25'h0777777};
    logic [23:0] sum;
    logic        cout;
    int          lat;
    bit          to;
    for (int i = 0; i < 4; i++) begin
      run24(va[i], vb[i], vc[i], i, sum, cout, lat, to);
      checks++;
      if (to || {cout, sum} !== exp_v[i] || lat != 8) begin
        errors++;
        $display("FAIL directed_%0d got cout=%b sum=%h lat=%0d to=%0b, required %h lat=8",
                 i, cout, sum, lat, to, exp_v[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] sum;
    logic        cout;
    int          lat;
    in_a = 24'hABCDEF; in_b = 24'h111111; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    checks++;
    if ({out_cout, out_sum} !== 25'h0BCDF01 || lat != 8) begin
      errors++;
      $display("FAIL bp_result got cout=%b sum=%h lat=%0d, required 0bcdf01 lat=8",
               out_cout, out_sum, lat);
    end
    sum = out_sum; cout = out_cout;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; in_a = 24'($urandom); in_b = 24'($urandom); in_cin = 1'($urandom);
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== sum || out_cout !== cout) begin
        errors++;
        $display("FAIL bp_hold_%0d valid=%b ready=%b sum=%h cout=%b, required 1 0 %h %b",
                 i, out_valid, in_ready, out_sum, out_cout, sum, cout);
      end
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release ready=%b valid=%b busy=%b, required 1 0 0",
               in_ready, out_valid, busy);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_stray busy=%b valid=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_in_run();
    logic [23:0] sum;
    logic        cout;
    int          lat;
    bit          to;
    in_a = 24'hFFFFFF; in_b = 24'hFFFFFF; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL run_busy busy=%b, required 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 24'h0 || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL run_reset valid=%b busy=%b sum=%h cout=%b, required 0 0 000000 0",
               out_valid, busy, out_sum, out_cout);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL run_reset_ready ready=%b valid=%b, required 1 0", in_ready, out_valid);
    end
    run24(24'h00000F, 24'h000001, 1'b0, 0, sum, cout, lat, to);
    checks++;
    if (to || sum !== 24'h000010 || cout !== 1'b0 || lat != 8) begin
      errors++;
      $display("FAIL after_reset sum=%h cout=%b lat=%0d to=%0b, required 000010 0 lat=8",
               sum, cout, lat, to);
    end
  endtask

  task automatic test_random24();
    logic [23:0] a, b, sum;
    logic        cin, cout;
    logic [24:0] ref_v;
    int          lat;
    bit          to;
    for (int i = 0; i < 1000; i++) begin
      a = 24'($urandom); b = 24'($urandom); cin = 1'($urandom);
      ref_v = 25'(a) + 25'(b) + 25'(cin);
      run24(a, b, cin, int'($urandom_range(0, 3)), sum, cout, lat, to);
      checks++;
      if (to || {cout, sum} !== ref_v || lat != 8) begin
        errors++;
        $display("FAIL rand24_%0d a=%h b=%h cin=%b got %b_%h lat=%0d, required %h lat=8",
                 i, a, b, cin, cout, sum, lat, ref_v);
      end
    end
  endtask

  task automatic test_random3();
    logic [2:0] a, b, sum;
    logic       cin, cout;
    logic [3:0] ref_v;
    int         lat;
    bit         to;
    for (int i = 0; i < 1000; i++) begin
      a = 3'($urandom); b = 3'($urandom); cin = 1'($urandom);
      ref_v = 4'(a) + 4'(b) + 4'(cin);
      run3(a, b, cin, int'($urandom_range(0, 3)), sum, cout, lat, to);
      checks++;
      if (to || {cout, sum} !== ref_v || lat != 1) begin
        errors++;
        $display("FAIL rand3_%0d a=%h b=%h cin=%b got %b_%h lat=%0d, required %h lat=1",
                 i, a, b, cin, cout, sum, lat, ref_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_in_run();
    test_random24();
    test_random3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
